// File: rtl/fc_layer_stream.sv
// Streaming fully-connected layer y = sat((W*x + b) >>> FRAC) with P MAC lanes.
// Define FC_LAYER_RELU_EN to clamp each stored result at zero.
module fc_layer_stream #(
  parameter int M    = 4,
  parameter int N    = 8,
  parameter int T    = 16,
  parameter int P    = 2,
  parameter int FRAC = 0,
  localparam int AW  = (M * N > 1) ? $clog2(M * N) : 1,
  localparam int BW  = (M > 1) ? $clog2(M) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic signed [T-1:0] s_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic signed [T-1:0] m_data,
  input  logic                w_wr_en,
  input  logic [AW-1:0]       w_addr,
  input  logic signed [T-1:0] w_data,
  input  logic                b_wr_en,
  input  logic [BW-1:0]       b_addr,
  input  logic signed [T-1:0] b_data,
  output logic                busy
);

  localparam int G    = M / P;
  localparam int CW   = (N > 1) ? $clog2(N) : 1;
  localparam int GW   = (G > 1) ? $clog2(G) : 1;
  localparam int ACCW = 2 * T + $clog2(N + 1);

  if (P < 1 || P > M || (M % P) != 0) begin : g_bad_p
    $error("fc_layer_stream: P must divide M and satisfy 1 <= P <= M");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_X,
    S_MAC,
    S_WB,
    S_OUT
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] xi_q, xi_d;
  logic [CW-1:0] col_q, col_d;
  logic [GW-1:0] grp_q, grp_d;
  logic [BW-1:0] out_q, out_d;

  logic signed [ACCW-1:0] acc_q [P];
  logic signed [ACCW-1:0] acc_d [P];

  logic signed [T-1:0] w_q [M*N];
  logic signed [T-1:0] w_d [M*N];
  logic signed [T-1:0] b_q [M];
  logic signed [T-1:0] b_d [M];
  logic signed [T-1:0] x_q [N];
  logic signed [T-1:0] x_d [N];
  logic signed [T-1:0] y_q [M];
  logic signed [T-1:0] y_d [M];

  logic [BW-1:0]          row  [P];
  logic [AW-1:0]          widx [P];
  logic signed [ACCW-1:0] prod [P];
  logic signed [ACCW-1:0] bext [P];
  logic signed [ACCW-1:0] sh   [P];
  logic signed [T-1:0]    res  [P];

  logic x_last, col_last, grp_last, out_last;

  assign x_last   = (xi_q == CW'(N - 1));
  assign col_last = (col_q == CW'(N - 1));
  assign grp_last = (grp_q == GW'(G - 1));
  assign out_last = (out_q == BW'(M - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      xi_q    <= '0;
      col_q   <= '0;
      grp_q   <= '0;
      out_q   <= '0;
      for (int p = 0; p < P; p++) acc_q[p] <= '0;
    end else begin
      state_q <= state_d;
      xi_q    <= xi_d;
      col_q   <= col_d;
      grp_q   <= grp_d;
      out_q   <= out_d;
      acc_q   <= acc_d;
    end
  end

  // Buffers survive reset; only explicit writes change W and b.
  always_ff @(posedge clk) begin
    w_q <= w_d;
    b_q <= b_d;
    x_q <= x_d;
    y_q <= y_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:
        if (s_valid) state_d = (N == 1) ? S_MAC : S_LOAD_X;
      S_LOAD_X:
        if (s_valid && x_last) state_d = S_MAC;
      S_MAC:
        if (col_last) state_d = S_WB;
      S_WB:
        state_d = grp_last ? S_OUT : S_MAC;
      S_OUT:
        if (m_ready && out_last) state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    s_ready = (state_q == S_IDLE) || (state_q == S_LOAD_X);
    m_valid = (state_q == S_OUT);
    busy    = (state_q != S_IDLE);
    m_data  = (state_q == S_OUT) ? y_q[out_q] : '0;
  end

  // Lane p serves row grp*P+p; full-precision product then saturate.
  always_comb begin
    for (int p = 0; p < P; p++) begin
      row[p]  = BW'(32'(grp_q) * P + p);
      widx[p] = AW'(32'(row[p]) * N + 32'(col_q));
      prod[p] = ACCW'(w_q[widx[p]]) * ACCW'(x_q[col_q]);
      bext[p] = ACCW'(b_q[row[p]]);
      sh[p]   = acc_q[p] >>> FRAC;
      if (sh[p] > $signed({{(ACCW-T+1){1'b0}}, {(T-1){1'b1}}}))
        res[p] = {1'b0, {(T-1){1'b1}}};
      else if (sh[p] < $signed({{(ACCW-T+1){1'b1}}, {(T-1){1'b0}}}))
        res[p] = {1'b1, {(T-1){1'b0}}};
      else
        res[p] = sh[p][T-1:0];
`ifdef FC_LAYER_RELU_EN
      if (res[p][T-1]) res[p] = '0;
`endif
    end
  end

  always_comb begin
    xi_d  = xi_q;
    col_d = col_q;
    grp_d = grp_q;
    out_d = out_q;
    acc_d = acc_q;
    w_d   = w_q;
    b_d   = b_q;
    x_d   = x_q;
    y_d   = y_q;
    case (state_q)
      S_IDLE: begin
        if (w_wr_en && 32'(w_addr) < M * N) w_d[w_addr] = w_data;
        if (b_wr_en && 32'(b_addr) < M) b_d[b_addr] = b_data;
        if (s_valid) begin
          x_d[0] = s_data;
          xi_d   = (N == 1) ? '0 : CW'(1);
        end
      end
      S_LOAD_X:
        if (s_valid) begin
          x_d[xi_q] = s_data;
          xi_d      = x_last ? '0 : xi_q + 1'b1;
        end
      S_MAC: begin
        for (int p = 0; p < P; p++)
          acc_d[p] = ((col_q == '0) ? bext[p] : acc_q[p]) + prod[p];
        col_d = col_last ? '0 : col_q + 1'b1;
      end
      S_WB: begin
        for (int p = 0; p < P; p++) y_d[row[p]] = res[p];
        grp_d = grp_last ? '0 : grp_q + 1'b1;
      end
      S_OUT:
        if (m_ready) out_d = out_last ? '0 : out_q + 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fc_layer_stream.sv
// Scoreboard bench for fc_layer_stream: M=2 N=2 T=8, one P=1 and one P=2 instance.
// Expected y values are hand-computed from W=[2,-6;3,-1], b=[6,0].
module tb_fc_layer_stream;

  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;

  logic              s_valid [2];
  logic              s_ready [2];
  logic signed [7:0] s_data  [2];
  logic              m_valid [2];
  logic              m_ready [2];
  logic signed [7:0] m_data  [2];
  logic              w_wr_en [2];
  logic [1:0]        w_addr  [2];
  logic signed [7:0] w_data  [2];
  logic              b_wr_en [2];
  logic [0:0]        b_addr  [2];
  logic signed [7:0] b_data  [2];
  logic              busy    [2];

  fc_layer_stream #(.M(2), .N(2), .T(8), .P(1), .FRAC(0)) u_p1 (
    .clk(clk), .reset(reset),
    .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data[0]),
    .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_data(m_data[0]),
    .w_wr_en(w_wr_en[0]), .w_addr(w_addr[0]), .w_data(w_data[0]),
    .b_wr_en(b_wr_en[0]), .b_addr(b_addr[0]), .b_data(b_data[0]),
    .busy(busy[0])
  );

  fc_layer_stream #(.M(2), .N(2), .T(8), .P(2), .FRAC(0)) u_p2 (
    .clk(clk), .reset(reset),
    .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data[1]),
    .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_data(m_data[1]),
    .w_wr_en(w_wr_en[1]), .w_addr(w_addr[1]), .w_data(w_data[1]),
    .b_wr_en(b_wr_en[1]), .b_addr(b_addr[1]), .b_data(b_data[1]),
    .busy(busy[1])
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int exp0 [$];
  int exp1 [$];
  logic hold [2];
  int hold_d [2];

  always @(posedge clk) cyc++;

  task automatic chk(string name, int act, int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic push(int d, int y0, int y1);
    if (d == 0) begin exp0.push_back(y0); exp0.push_back(y1); end
    else begin exp1.push_back(y0); exp1.push_back(y1); end
  endtask

  task automatic mon(int d);
    int e;
    if (!reset && m_valid[d] && hold[d])
      chk($sformatf("hold_stable%0d", d), int'(m_data[d]), hold_d[d]);
    hold[d] = m_valid[d] && !m_ready[d];
    hold_d[d] = int'(m_data[d]);
    if (!reset && m_valid[d] && m_ready[d]) begin
      if ((d == 0 ? exp0.size() : exp1.size()) == 0) begin
        chk($sformatf("unexpected_y%0d", d), int'(m_data[d]), 9999);
      end else begin
        e = (d == 0) ? exp0.pop_front() : exp1.pop_front();
        chk($sformatf("y_dut%0d", d), int'(m_data[d]), e);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic wr_w(int d, int a, int v);
    w_wr_en[d] = 1; w_addr[d] = 2'(a); w_data[d] = 8'(v);
    @(posedge clk); #1;
    w_wr_en[d] = 0;
  endtask

  task automatic wr_b(int d, int a, int v);
    b_wr_en[d] = 1; b_addr[d] = 1'(a); b_data[d] = 8'(v);
    @(posedge clk); #1;
    b_wr_en[d] = 0;
  endtask

  task automatic send(int d, int x0, int x1);
    int xs [2];
    bit ok;
    xs[0] = x0; xs[1] = x1;
    for (int k = 0; k < 2; k++) begin
      s_valid[d] = 1; s_data[d] = 8'(xs[k]);
      ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
        @(negedge clk);
        if (s_ready[d]) begin ok = 1; hs_cyc = cyc; end
      end
      if (!ok) chk("s_ready_timeout", 0, 1);
      @(posedge clk); #1;
    end
    s_valid[d] = 0;
  endtask

  task automatic drain(int d);
    for (int i = 0; i < 100 && (d == 0 ? exp0.size() : exp1.size()) != 0; i++)
      @(negedge clk);
    chk($sformatf("drain%0d", d), (d == 0) ? exp0.size() : exp1.size(), 0);
    @(negedge clk);
    chk($sformatf("idle_ready%0d", d), int'(s_ready[d]), 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(int d);
    bit ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (m_valid[d]) ok = 1;
    end
    if (!ok) chk("m_valid_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      s_valid[d] = 0; s_data[d] = 0; m_ready[d] = 1;
      w_wr_en[d] = 0; w_addr[d] = 0; w_data[d] = 0;
      b_wr_en[d] = 0; b_addr[d] = 0; b_data[d] = 0;
      hold[d] = 0; hold_d[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_m_valid%0d", d), int'(m_valid[d]), 0);
      chk($sformatf("rst_busy%0d", d), int'(busy[d]), 0);
      chk($sformatf("rst_m_data%0d", d), int'(m_data[d]), 0);
      chk($sformatf("rst_s_ready%0d", d), int'(s_ready[d]), 1);
    end
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      wr_w(d, 0, 2); wr_w(d, 1, -6); wr_w(d, 2, 3); wr_w(d, 3, -1);
      wr_b(d, 0, 6); wr_b(d, 1, 0);
    end

    // x=[1,1] streaming, latency from x[1] handshake
    push(0, 2, 2);
    send(0, 1, 1);
    wait_valid(0);
    chk("latency", cyc - hs_cyc, 7);
    drain(0);

    // negative result with and without ReLU
`ifdef FC_LAYER_RELU_EN
    push(0, 0, 0);
`else
    push(0, 0, -1);
`endif
    send(0, 0, 1);
    drain(0);

    // saturation at both rails
`ifdef FC_LAYER_RELU_EN
    push(0, 0, 127);
`else
    push(0, -128, 127);
`endif
    send(0, 127, 127);
    drain(0);

    // backpressure: y0 must hold while m_ready is low
    m_ready[0] = 0;
    push(0, 10, 6);
    send(0, 2, 0);
    wait_valid(0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_data", int'(m_data[0]), 10);
      @(negedge clk);
    end
    @(posedge clk); #1;
    m_ready[0] = 1;
    drain(0);

    // reset in the middle of MAC discards the transaction
    send(0, 1, 1);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("midrst_m_valid", int'(m_valid[0]), 0);
    chk("midrst_s_ready", int'(s_ready[0]), 1);
    @(posedge clk); #1;
    push(0, 2, 2);
    send(0, 1, 1);
    drain(0);

    // P=2: weight write during OUT must be ignored
    m_ready[1] = 0;
    push(1, 2, 2);
    send(1, 1, 1);
    wait_valid(1);
    @(posedge clk); #1;
    wr_w(1, 3, 5);
    m_ready[1] = 1;
    drain(1);
    push(1, 2, 2);
    send(1, 1, 1);
    drain(1);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
